// File: rtl/riscv_defines.sv
// Shared DIFT type definitions used by the tag check unit.
//   dift_tag_t        : tag attached to an instruction word or operand
//   dift_opclass_t    : coarse operation class of the instruction in EX
//   dift_checkpol_t   : check policy register, bit layout matches tcr_i
//   dift_checkcause_t : violation cause codes reported to the controller
package riscv_defines;

    localparam int DIFT_TAG_W = 4;

    typedef logic [DIFT_TAG_W-1:0] dift_tag_t;

    typedef enum logic [2:0] {
        DIFT_OP_OTHER  = 3'd0,
        DIFT_OP_ALU    = 3'd1,
        DIFT_OP_JUMP   = 3'd2,
        DIFT_OP_BRANCH = 3'd3,
        DIFT_OP_LOAD   = 3'd4,
        DIFT_OP_STORE  = 3'd5
    } dift_opclass_t;

    // Declared MSB first so the struct lines up with tcr_i[7:0].
    typedef struct packed {
        logic enable;      // [7]
        logic trap_en;     // [6]
        logic reserved;    // [5]
        logic exec;        // [4]
        logic load_addr;   // [3]
        logic store_addr;  // [2]
        logic branch;      // [1]
        logic jump;        // [0]
    } dift_checkpol_t;

    typedef enum logic [2:0] {
        DIFT_CAUSE_NONE       = 3'd0,
        DIFT_CAUSE_EXEC       = 3'd1,
        DIFT_CAUSE_JUMP       = 3'd2,
        DIFT_CAUSE_BRANCH     = 3'd3,
        DIFT_CAUSE_STORE_ADDR = 3'd4,
        DIFT_CAUSE_LOAD_ADDR  = 3'd5
    } dift_checkcause_t;

    typedef enum logic {
        DIFT_CHK_IDLE    = 1'b0,
        DIFT_CHK_PENDING = 1'b1
    } dift_chk_state_t;

    function automatic logic dift_tagged(input dift_tag_t t);
        return |t;
    endfunction

endpackage

// File: rtl/dift_check_eval.sv
// Combinational policy evaluation for the instruction in EX.
//   valid_i          : instruction valid and retiring
//   opclass_i        : operation class
//   instr_tag_i      : tag of the instruction word
//   operand_a_tag_i  : tag of operand A (jump target / address base)
//   operand_b_tag_i  : tag of operand B
//   pol_i            : check policy
//   violation_o      : some enabled check fired
//   cause_o          : prioritised cause (NONE when no violation)
module dift_check_eval
    import riscv_defines::*;
(
    input  logic             valid_i,
    input  dift_opclass_t    opclass_i,
    input  dift_tag_t        instr_tag_i,
    input  dift_tag_t        operand_a_tag_i,
    input  dift_tag_t        operand_b_tag_i,
    input  dift_checkpol_t   pol_i,
    output logic             violation_o,
    output dift_checkcause_t cause_o
);

    logic active;
    logic hit_exec, hit_jump, hit_branch, hit_store, hit_load;

    // trap_en only matters to the FSM; reserved has no meaning yet.
    logic unused_pol;
    assign unused_pol = pol_i.trap_en ^ pol_i.reserved;

    assign active     = valid_i & pol_i.enable;
    assign hit_exec   = pol_i.exec & dift_tagged(instr_tag_i);
    assign hit_jump   = (opclass_i == DIFT_OP_JUMP) & pol_i.jump
                        & dift_tagged(operand_a_tag_i);
    assign hit_branch = (opclass_i == DIFT_OP_BRANCH) & pol_i.branch
                        & (dift_tagged(operand_a_tag_i) | dift_tagged(operand_b_tag_i));
    assign hit_store  = (opclass_i == DIFT_OP_STORE) & pol_i.store_addr
                        & dift_tagged(operand_a_tag_i);
    assign hit_load   = (opclass_i == DIFT_OP_LOAD) & pol_i.load_addr
                        & dift_tagged(operand_a_tag_i);

    assign violation_o = active & (hit_exec | hit_jump | hit_branch | hit_store | hit_load);

    // EXEC wins; the opclass-specific checks are mutually exclusive.
    always_comb begin
        cause_o = DIFT_CAUSE_NONE;
        if (active) begin
            if (hit_exec)        cause_o = DIFT_CAUSE_EXEC;
            else if (hit_jump)   cause_o = DIFT_CAUSE_JUMP;
            else if (hit_branch) cause_o = DIFT_CAUSE_BRANCH;
            else if (hit_store)  cause_o = DIFT_CAUSE_STORE_ADDR;
            else if (hit_load)   cause_o = DIFT_CAUSE_LOAD_ADDR;
        end
    end

endmodule

// File: rtl/dift_tag_check.sv
// DIFT tag check unit: enforces the check policy on the EX instruction,
// captures the offending cause/PC/tags and raises a held exception request.
//   clk, rst         : core clock, synchronous active-high reset
//   valid_i          : EX instruction valid and retiring
//   opclass_i, pc_i  : operation class and PC of the EX instruction
//   *_tag_i          : instruction and operand tags
//   tcr_i            : check policy
//   exc_ack_i        : controller took the pending exception
//   clear_i          : clear violation counter and overflow flag
//   exc_req_o        : exception request, held until acknowledged
//   exc_cause_o, exc_pc_o, exc_tags_o : captured violation ([0]=instr, [1]=a, [2]=b)
//   viol_cnt_o       : saturating violation count
//   overflow_o       : sticky, a violation was dropped while one was pending
module dift_tag_check
    import riscv_defines::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  dift_opclass_t        opclass_i,
    input  logic [31:0]          pc_i,
    input  dift_tag_t            instr_tag_i,
    input  dift_tag_t            operand_a_tag_i,
    input  dift_tag_t            operand_b_tag_i,
    input  dift_checkpol_t       tcr_i,
    input  logic                 exc_ack_i,
    input  logic                 clear_i,
    output logic                 exc_req_o,
    output dift_checkcause_t     exc_cause_o,
    output logic [31:0]          exc_pc_o,
    output dift_tag_t [2:0]      exc_tags_o,
    output logic [CNT_WIDTH-1:0] viol_cnt_o,
    output logic                 overflow_o
);

    logic             violation;
    dift_checkcause_t cause;

    dift_check_eval u_eval (
        .valid_i         (valid_i),
        .opclass_i       (opclass_i),
        .instr_tag_i     (instr_tag_i),
        .operand_a_tag_i (operand_a_tag_i),
        .operand_b_tag_i (operand_b_tag_i),
        .pol_i           (tcr_i),
        .violation_o     (violation),
        .cause_o         (cause)
    );

    dift_chk_state_t state_q, state_d;
    logic            capture;
    logic            ovf_set;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            DIFT_CHK_IDLE: begin
                if (violation) begin
                    capture = 1'b1;
                    // Log-only mode records the violation but never traps.
                    if (tcr_i.trap_en) state_d = DIFT_CHK_PENDING;
                end
            end
            DIFT_CHK_PENDING: begin
                if (exc_ack_i) begin
                    // A violation in the ack cycle becomes the next pending one.
                    if (violation) capture = 1'b1;
                    else           state_d = DIFT_CHK_IDLE;
                end else if (violation) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_d = DIFT_CHK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= DIFT_CHK_IDLE;
        else     state_q <= state_d;
    end

    assign exc_req_o = (state_q == DIFT_CHK_PENDING);

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_cause_o <= DIFT_CAUSE_NONE;
            exc_pc_o    <= '0;
            exc_tags_o  <= '0;
        end else if (capture) begin
            exc_cause_o <= cause;
            exc_pc_o    <= pc_i;
            exc_tags_o  <= {operand_b_tag_i, operand_a_tag_i, instr_tag_i};
        end
    end

    // Clear applies first, so a violation in the clear cycle still counts.
    logic [CNT_WIDTH-1:0] cnt_base;
    assign cnt_base = clear_i ? '0 : viol_cnt_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            viol_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (violation && (cnt_base != {CNT_WIDTH{1'b1}}))
                viol_cnt_o <= cnt_base + 1'b1;
            else
                viol_cnt_o <= cnt_base;
            overflow_o <= ovf_set | (overflow_o & ~clear_i);
        end
    end

endmodule

// File: tb/tb_dift_tag_check.sv
module tb_dift_tag_check;
    import riscv_defines::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_i;
    dift_opclass_t    opclass_i;
    logic [31:0]      pc_i;
    dift_tag_t        instr_tag_i, operand_a_tag_i, operand_b_tag_i;
    dift_checkpol_t   tcr_i;
    logic             exc_ack_i, clear_i;
    logic             exc_req_o;
    dift_checkcause_t exc_cause_o;
    logic [31:0]      exc_pc_o;
    dift_tag_t [2:0]  exc_tags_o;
    logic [3:0]       viol_cnt_o;
    logic             overflow_o;

    dift_tag_check #(.CNT_WIDTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_i         (valid_i),
        .opclass_i       (opclass_i),
        .pc_i            (pc_i),
        .instr_tag_i     (instr_tag_i),
        .operand_a_tag_i (operand_a_tag_i),
        .operand_b_tag_i (operand_b_tag_i),
        .tcr_i           (tcr_i),
        .exc_ack_i       (exc_ack_i),
        .clear_i         (clear_i),
        .exc_req_o       (exc_req_o),
        .exc_cause_o     (exc_cause_o),
        .exc_pc_o        (exc_pc_o),
        .exc_tags_o      (exc_tags_o),
        .viol_cnt_o      (viol_cnt_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        req;
        logic [2:0]  cause;
        logic [31:0] pc;
        logic [11:0] tags;   // {b, a, instr}
        logic [3:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", n, f, act, exp);
        end
    endtask

    // Monitor: each cycle the outputs are compared against the expectation
    // queued by the driver for that edge.
    initial begin
        exp_t        e;
        logic [11:0] tags;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e    = q.pop_front();
                tags = exc_tags_o;
                chk(e.name, "req",   {31'd0, exc_req_o},         {31'd0, e.req});
                chk(e.name, "cause", {29'd0, exc_cause_o},       {29'd0, e.cause});
                chk(e.name, "pc",    exc_pc_o,                   e.pc);
                chk(e.name, "tags",  {20'd0, tags},              {20'd0, e.tags});
                chk(e.name, "cnt",   {28'd0, viol_cnt_o},        {28'd0, e.cnt});
                chk(e.name, "ovf",   {31'd0, overflow_o},        {31'd0, e.ovf});
            end
        end
    end

    function automatic exp_t mk(input string n, input bit req, input int cause, input int pc,
                                input int tags, input int cnt, input bit ovf);
        exp_t e;
        e.name = n; e.req = req; e.cause = cause[2:0]; e.pc = pc;
        e.tags = tags[11:0]; e.cnt = cnt[3:0]; e.ovf = ovf;
        return e;
    endfunction

    task automatic idle_in();
        valid_i = 0; opclass_i = DIFT_OP_OTHER; pc_i = 0;
        instr_tag_i = 0; operand_a_tag_i = 0; operand_b_tag_i = 0;
        tcr_i = 8'h00; exc_ack_i = 0; clear_i = 0; rst = 0;
    endtask

    task automatic ins(input dift_opclass_t op, input int pc, input int it, input int at,
                       input int bt, input logic [7:0] tcr);
        valid_i = 1; opclass_i = op; pc_i = pc;
        instr_tag_i = it[3:0]; operand_a_tag_i = at[3:0]; operand_b_tag_i = bt[3:0];
        tcr_i = tcr;
    endtask

    // Inputs are set at the negedge before calling; the expectation is for the next edge.
    task automatic step(input exp_t e);
        q.push_back(e);
        @(negedge clk);
        idle_in();
    endtask

    initial begin
        idle_in();
        rst = 1;
        @(negedge clk);
        // Reset cycle with a live violation: must be discarded.
        rst = 1; ins(DIFT_OP_JUMP, 'h80, 0, 1, 0, 8'hC1);
        step(mk("reset", 0, 0, 0, 0, 0, 0));
        step(mk("post_reset_idle", 0, 0, 0, 0, 0, 0));
        // Trapping jump violation.
        ins(DIFT_OP_JUMP, 'h100, 0, 1, 0, 8'hC1);
        step(mk("jump_trap", 1, 2, 'h100, 'h010, 1, 0));
        step(mk("jump_held", 1, 2, 'h100, 'h010, 1, 0));
        exc_ack_i = 1;
        step(mk("jump_ack", 0, 2, 'h100, 'h010, 1, 0));
        step(mk("idle_after_ack", 0, 2, 'h100, 'h010, 1, 0));
        exc_ack_i = 1;
        step(mk("ack_in_idle", 0, 2, 'h100, 'h010, 1, 0));
        // EXEC takes priority over store address check.
        ins(DIFT_OP_STORE, 'h104, 1, 1, 0, 8'hD4);
        step(mk("exec_prio", 1, 1, 'h104, 'h011, 2, 0));
        // Second violation while pending, no ack: dropped, overflow set.
        ins(DIFT_OP_JUMP, 'h200, 0, 2, 0, 8'hC1);
        step(mk("overflow", 1, 1, 'h104, 'h011, 3, 1));
        clear_i = 1;
        step(mk("clear", 1, 1, 'h104, 'h011, 0, 0));
        // Ack plus new load violation in the same cycle: recapture, stay pending.
        exc_ack_i = 1; ins(DIFT_OP_LOAD, 'h300, 0, 3, 0, 8'hC8);
        step(mk("ack_recapture", 1, 5, 'h300, 'h030, 1, 0));
        exc_ack_i = 1;
        step(mk("ack_load", 0, 5, 'h300, 'h030, 1, 0));
        // Log-only branch on operand b.
        ins(DIFT_OP_BRANCH, 'h400, 0, 0, 5, 8'h82);
        step(mk("log_only_branch", 0, 3, 'h400, 'h500, 2, 0));
        // No-violation cases.
        ins(DIFT_OP_JUMP, 'h440, 15, 15, 15, 8'hFF); valid_i = 0;
        step(mk("valid_low", 0, 3, 'h400, 'h500, 2, 0));
        ins(DIFT_OP_JUMP, 'h444, 15, 15, 15, 8'h7F);
        step(mk("enable_low", 0, 3, 'h400, 'h500, 2, 0));
        ins(DIFT_OP_ALU, 'h448, 0, 15, 15, 8'hCF);
        step(mk("alu_no_check", 0, 3, 'h400, 'h500, 2, 0));
        // Clear and violation together give count 1.
        clear_i = 1; ins(DIFT_OP_BRANCH, 'h500, 0, 1, 0, 8'h82);
        step(mk("clear_and_viol", 0, 3, 'h500, 'h010, 1, 0));
        // Saturation at 15.
        for (int i = 0; i < 17; i++) begin
            ins(DIFT_OP_JUMP, 'h600 + 4*i, 0, 1, 0, 8'h81);
            step(mk($sformatf("sat_%0d", i), 0, 2, 'h600 + 4*i, 'h010, (i + 2 > 15) ? 15 : i + 2, 0));
        end
        ins(DIFT_OP_JUMP, 'h700, 0, 4, 0, 8'hC1);
        step(mk("trap_saturated", 1, 2, 'h700, 'h040, 15, 0));
        // Dropping enable while pending keeps the request.
        step(mk("enable_off_pending", 1, 2, 'h700, 'h040, 15, 0));
        // Reset mid-pending, with a violation in the reset cycle.
        rst = 1; ins(DIFT_OP_JUMP, 'h800, 0, 1, 0, 8'hC1);
        step(mk("reset_pending", 0, 0, 0, 0, 0, 0));
        step(mk("after_reset", 0, 0, 0, 0, 0, 0));
        done = 1;
    end

    initial begin
        int cyc = 0;
        wait (done);
        while (q.size() > 0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
